// File: rtl/bp_pred_queue_pkg.sv
// Shared branch-prediction types: core configuration, per-slot prediction
// record, and the rule for which PC bits identify a fetch block.
package bp_pred_queue_pkg;

  typedef struct packed {
    int unsigned VLEN;
    int unsigned INSTR_PER_FETCH;
    bit          RVC;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32, INSTR_PER_FETCH: 2, RVC: 1'b1};

  typedef struct packed {
    logic valid;
    logic taken;
  } bht_pred_t;

  // Compressed instructions shrink the per-instruction address step to 2 bytes.
  function automatic int unsigned fetch_offset(input cva6_cfg_t cfg);
    return cfg.RVC ? 1 : 2;
  endfunction

  function automatic int unsigned block_lsb(input cva6_cfg_t cfg);
    return $clog2(cfg.INSTR_PER_FETCH) + fetch_offset(cfg);
  endfunction

endpackage

// File: rtl/bp_final_select.sv
// Per-slot chooser mux: the selected predictor wins unless it has no
// prediction, in which case the other one is used.
module bp_final_select
  import bp_pred_queue_pkg::*;
#(
  parameter type bht_prediction_t = bht_pred_t
) (
  input  bht_prediction_t gbp,
  input  bht_prediction_t lbp,
  input  logic            sel,
  output bht_prediction_t pred
);

  bht_prediction_t chosen;
  bht_prediction_t other;

  assign chosen = sel ? gbp : lbp;
  assign other  = sel ? lbp : gbp;

  always_comb begin
    pred = '0;
    if (chosen.valid) begin
      pred = chosen;
    end else if (other.valid) begin
      pred = other;
    end
  end

endmodule

// File: rtl/bp_pred_queue.sv
// In-flight prediction queue: records both predictor results per fetch block
// and replays them, oldest first, when the block resolves.
module bp_pred_queue
  import bp_pred_queue_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg          = cva6_cfg_empty,
  parameter type         bht_prediction_t = bht_pred_t,
  parameter int unsigned DEPTH            = 8
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          flush_i,
  input  logic                                          push_valid_i,
  output logic                                          push_ready_o,
  input  logic            [CVA6Cfg.VLEN-1:0]            push_pc_i,
  input  bht_prediction_t [CVA6Cfg.INSTR_PER_FETCH-1:0] gbp_pred_i,
  input  bht_prediction_t [CVA6Cfg.INSTR_PER_FETCH-1:0] lbp_pred_i,
  input  logic            [CVA6Cfg.INSTR_PER_FETCH-1:0] select_i,
  output bht_prediction_t [CVA6Cfg.INSTR_PER_FETCH-1:0] final_pred_o,
  input  logic                                          resolve_valid_i,
  input  logic            [CVA6Cfg.VLEN-1:0]            resolve_pc_i,
  output logic                                          update_valid_o,
  output logic            [CVA6Cfg.VLEN-1:0]            update_pc_o,
  output bht_prediction_t [CVA6Cfg.INSTR_PER_FETCH-1:0] update_gbp_pred_o,
  output bht_prediction_t [CVA6Cfg.INSTR_PER_FETCH-1:0] update_lbp_pred_o,
  output logic                                          update_mismatch_o,
  output logic            [$clog2(DEPTH):0]             count_o
);

  localparam int unsigned VLEN    = CVA6Cfg.VLEN;
  localparam int unsigned IPF     = CVA6Cfg.INSTR_PER_FETCH;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned BLK_LSB = block_lsb(CVA6Cfg);

  typedef struct packed {
    logic            [VLEN-1:0] pc;
    bht_prediction_t [IPF-1:0]  gbp;
    bht_prediction_t [IPF-1:0]  lbp;
  } entry_t;

  // Offset bits within a fetch block are ignored.
  function automatic logic block_differs(input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
    return ((a ^ b) >> BLK_LSB) != '0;
  endfunction

  for (genvar i = 0; i < IPF; i++) begin : g_sel
    bp_final_select #(
      .bht_prediction_t(bht_prediction_t)
    ) u_final_select (
      .gbp (gbp_pred_i[i]),
      .lbp (lbp_pred_i[i]),
      .sel (select_i[i]),
      .pred(final_pred_o[i])
    );
  end

  entry_t           mem [DEPTH];
  entry_t           head_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             push;

  assign head_entry   = mem[head];
  assign pop          = resolve_valid_i & (count != '0);
  assign push_ready_o = (count < CNT_W'(DEPTH)) | pop;
  assign push         = push_valid_i & push_ready_o;
  assign count_o      = count;

  // Stage p0: entry storage and queue pointers
  always_ff @(posedge clk_i) begin
    if (push & ~flush_i) begin
      mem[tail] <= '{pc: push_pc_i, gbp: gbp_pred_i, lbp: lbp_pred_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop);
      tail  <= tail + PTR_W'(push);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Stage p1: registered update record for the chooser training path
  logic                      vld_p1;
  logic                      mismatch_p1;
  logic [VLEN-1:0]           pc_p1;
  bht_prediction_t [IPF-1:0] gbp_p1;
  bht_prediction_t [IPF-1:0] lbp_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1      <= 1'b0;
      mismatch_p1 <= 1'b0;
      pc_p1       <= '0;
      gbp_p1      <= '0;
      lbp_p1      <= '0;
    end else begin
      vld_p1      <= pop;
      // A resolve against an empty queue is reported as a mismatch.
      mismatch_p1 <= resolve_valid_i & (~pop | block_differs(head_entry.pc, resolve_pc_i));
      pc_p1       <= pop ? resolve_pc_i : '0;
      gbp_p1      <= pop ? head_entry.gbp : '0;
      lbp_p1      <= pop ? head_entry.lbp : '0;
    end
  end

  assign update_valid_o    = vld_p1;
  assign update_mismatch_o = mismatch_p1;
  assign update_pc_o       = pc_p1;
  assign update_gbp_pred_o = gbp_p1;
  assign update_lbp_pred_o = lbp_p1;

endmodule
